vending_controller: RTL and testbench

//  Parametrised credit/vend state machine for the vending datapath. Consumes

---
 rtl/vending_controller.sv | 176 +++++++++++++++++
 tb/tb_vending_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
//   Credit/vend state machine driven by debounced keypad events. Coin keys add
//   credit up to a ceiling. Item keys buy when credit covers the price. Cancel
//   refunds the whole credit. Dispense and change outputs are held for
//   HOLD_CYCLES clocks. Keys are ignored during that time.
//
// Ports
//   clk           in   1          system clock
//   reset         in   1          asynchronous, active-low reset
//   key_code      in   4          debounced key number (0-3 coin, 4.. item, E cancel)
//   key_valid     in   1          one-cycle strobe qualifying key_code
//   credit        out  CREDIT_W   current credit, binary
//   dispense      out  N_ITEMS    one-hot vend strobe, held HOLD_CYCLES
//   change        out  CREDIT_W   refund amount, valid while change_valid
//   change_valid  out  1          refund in progress, held HOLD_CYCLES
//   coin_reject   out  1          one-cycle pulse: coin would exceed MAX_CREDIT
//   deny          out  1          one-cycle pulse: item key with too little credit
//   busy          out  1          high in DISPENSE or CHANGE; keys ignored
// -----------------------------------------------------------------------------
module vending_controller #(
    parameter int                          CREDIT_W    = 8,
    parameter int                          MAX_CREDIT  = 200,
    parameter int                          N_ITEMS     = 4,
    parameter logic [4*CREDIT_W-1:0]       COIN_VALS   = {8'd50, 8'd25, 8'd10, 8'd5},
    parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {N_ITEMS{CREDIT_W'(75)}},
    parameter int                          HOLD_CYCLES = 50_000_000,
    parameter bit                          AUTO_CHANGE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          key_code,
    input  logic                key_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  dispense,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy
);

    // Coin values and prices are CREDIT_W-bit slices, so they are in range by
    // construction. Only the ceiling and the item count need checking.
    if (MAX_CREDIT < 0 || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max_credit
        $error("vending_controller: MAX_CREDIT does not fit in CREDIT_W bits");
    end
    if (N_ITEMS < 1 || N_ITEMS > 8) begin : g_bad_n_items
        $error("vending_controller: N_ITEMS must be 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("vending_controller: HOLD_CYCLES must be >= 1");
    end

    localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0]  HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [3:0]          KEY_CANCEL = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_CHANGE   = 2'd2
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;

    // Key decode
    logic                 is_coin;
    logic                 is_item;
    logic                 is_cancel;
    logic [2:0]           item_idx;
    logic [CREDIT_W-1:0]  coin_val;
    logic [CREDIT_W-1:0]  item_price;
    logic [CREDIT_W:0]    coin_sum;

    assign is_coin   = (key_code[3:2] == 2'b00);
    assign is_item   = (key_code >= 4'd4) && ({1'b0, key_code} < 5'(4 + N_ITEMS));
    assign is_cancel = (key_code == KEY_CANCEL);
    assign item_idx  = 3'(key_code - 4'd4);

    // NOTE: every variable assigned in always_comb gets a default first, so a
    // key that matches no table entry cannot infer a latch.
    always_comb begin
        coin_val   = '0;
        item_price = '0;
        for (int k = 0; k < 4; k++) begin
            if (key_code[1:0] == 2'(k)) coin_val = COIN_VALS[k*CREDIT_W +: CREDIT_W];
        end
        for (int i = 0; i < N_ITEMS; i++) begin
            if (item_idx == 3'(i)) item_price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
        end
    end

    // One extra bit so an overflowing coin is seen as over the ceiling rather
    // than wrapping to a small credit.
    assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values and updates together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            credit       <= '0;
            dispense     <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_valid) begin
                        if (is_coin) begin
                            if (coin_sum <= MAX_SUM) credit <= coin_sum[CREDIT_W-1:0];
                            else                     coin_reject <= 1'b1;
                        end else if (is_item) begin
                            if (credit >= item_price) begin
                                credit   <= credit - item_price;
                                dispense <= N_ITEMS'(1) << item_idx;
                                timer    <= HOLD_LOAD;
                                busy     <= 1'b1;
                                state    <= S_DISPENSE;
                            end else begin
                                deny <= 1'b1;
                            end
                        end else if (is_cancel && credit != '0) begin
                            change       <= credit;
                            credit       <= '0;
                            change_valid <= 1'b1;
                            timer        <= HOLD_LOAD;
                            busy         <= 1'b1;
                            state        <= S_CHANGE;
                        end
                    end
                end
                S_DISPENSE: begin
                    if (timer == '0) begin
                        dispense <= '0;
                        // Leftover credit goes straight to refund on the same
                        // edge, so dispense and change_valid never overlap.
                        if (AUTO_CHANGE && credit != '0) begin
                            change       <= credit;
                            credit       <= '0;
                            change_valid <= 1'b1;
                            timer        <= HOLD_LOAD;
                            state        <= S_CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                S_CHANGE: begin
                    if (timer == '0) begin
                        change_valid <= 1'b0;
                        change       <= '0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_controller.sv
// -----------------------------------------------------------------------------
// tb_vending_controller
//   Directed bench for vending_controller with default prices/coins and a short
//   hold time. A table covers single-cycle IDLE behaviour. Hand-written
//   sequences cover vend, auto-change, cancel, ignored keys and async reset.
//   Coin keys: 0->5, 1->10, 2->25, 3->50. Item price 75 for every item.
// -----------------------------------------------------------------------------
module tb_vending_controller;

    localparam int HOLD  = 4;
    localparam int LIMIT = 4 * HOLD + 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_code;
    logic       key_valid;
    logic [7:0] credit;
    logic [3:0] dispense;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       deny;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vending_controller #(.HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .credit       (credit),
        .dispense     (dispense),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .deny         (deny),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe one key for one clock; returns #1 after the edge that samples it.
    task automatic press(input logic [3:0] k, input logic v);
        @(negedge clk);
        key_code  = k;
        key_valid = v;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Count consecutive cycles the chosen output stays high, from the current
    // sample point. sel 0: any dispense bit, 1: change_valid.
    task automatic measure_hold(input int sel, output int cycles);
        cycles = 0;
        while (((sel == 0) ? (|dispense) : change_valid) && cycles < LIMIT) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic       valid;
        logic [3:0] key;
        logic [7:0] exp_credit;
        logic       exp_reject;
        logic       exp_deny;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 4'h4, 8'd0,   1'b0, 1'b1};  // buy with no credit
        vecs[1]  = '{1'b1, 4'h2, 8'd25,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h2, 8'd50,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'h2, 8'd50,  1'b0, 1'b0};  // no strobe
        vecs[4]  = '{1'b1, 4'h2, 8'd75,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'h3, 8'd125, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'h3, 8'd175, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'h3, 8'd175, 1'b1, 1'b0};  // 225 > 200
        vecs[8]  = '{1'b1, 4'h2, 8'd200, 1'b0, 1'b0};  // exactly the ceiling
        vecs[9]  = '{1'b1, 4'h0, 8'd200, 1'b1, 1'b0};  // one coin over
        vecs[10] = '{1'b1, 4'hF, 8'd200, 1'b0, 1'b0};  // unmapped key
        vecs[11] = '{1'b1, 4'h8, 8'd200, 1'b0, 1'b0};  // beyond last item
        vecs[12] = '{1'b1, 4'hD, 8'd200, 1'b0, 1'b0};  // unmapped key

        reset     = 1'b0;
        key_code  = 4'h0;
        key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_credit", credit, 0);
        check("reset_outputs", {dispense, change, change_valid, coin_reject, deny, busy}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single-cycle IDLE behaviour
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].key, vecs[i].valid);
            check($sformatf("vec%0d_credit", i), credit, vecs[i].exp_credit);
            check($sformatf("vec%0d_reject", i), coin_reject, vecs[i].exp_reject);
            check($sformatf("vec%0d_deny", i), deny, vecs[i].exp_deny);
            check($sformatf("vec%0d_busy", i), {busy, dispense, change_valid}, 0);
        end

        // Cancel at 200: full refund, held HOLD cycles
        press(4'hE, 1'b1);
        check("cancel_change", change, 200);
        check("cancel_credit", credit, 0);
        check("cancel_busy", {busy, change_valid}, 2'b11);
        measure_hold(1, n);
        check("cancel_hold", n, HOLD);
        check("cancel_idle", {busy, change}, 0);

        // Exact-price vend: 75 then key 4, no change phase
        repeat (3) press(4'h2, 1'b1);
        check("exact_credit_before", credit, 75);
        press(4'h4, 1'b1);
        check("exact_dispense", dispense, 4'b0001);
        check("exact_credit", credit, 0);
        check("exact_busy", busy, 1'b1);
        measure_hold(0, n);
        check("exact_hold", n, HOLD);
        check("exact_no_change", {change_valid, change}, 0);
        check("exact_idle", busy, 1'b0);

        // Vend item 1 from 100 with auto-change of 25
        press(4'h3, 1'b1);
        press(4'h3, 1'b1);
        check("auto_credit_before", credit, 100);
        press(4'h5, 1'b1);
        check("auto_dispense", dispense, 4'b0010);
        check("auto_credit_mid", credit, 25);
        check("auto_cv_during", change_valid, 1'b0);
        measure_hold(0, n);
        check("auto_disp_hold", n, HOLD);
        check("auto_change", change, 25);
        check("auto_cv", change_valid, 1'b1);
        check("auto_credit", credit, 0);
        check("auto_busy", busy, 1'b1);
        measure_hold(1, n);
        check("auto_change_hold", n, HOLD);
        check("auto_idle", {busy, change, dispense}, 0);

        // Deny keeps credit; cancel refunds it; cancel at zero does nothing
        press(4'h3, 1'b1);
        press(4'h4, 1'b1);
        check("deny_pulse", deny, 1'b1);
        check("deny_credit", credit, 50);
        check("deny_no_vend", {busy, dispense}, 0);
        press(4'hE, 1'b1);
        check("deny_cleared", deny, 1'b0);
        check("refund_change", change, 50);
        check("refund_credit", credit, 0);
        measure_hold(1, n);
        check("refund_hold", n, HOLD);
        press(4'hE, 1'b1);
        check("cancel_zero", {busy, change_valid, change, credit}, 0);

        // Keys during DISPENSE are ignored
        repeat (3) press(4'h2, 1'b1);
        press(4'h4, 1'b1);
        press(4'h3, 1'b1);
        press(4'hE, 1'b1);
        check("busy_ignore_credit", credit, 0);
        check("busy_ignore_disp", dispense, 4'b0001);
        check("busy_ignore_cv", change_valid, 1'b0);
        measure_hold(0, n);
        check("busy_ignore_rest", n, HOLD - 2);
        check("busy_ignore_end", {credit, change_valid, busy}, 0);

        // Async reset mid-DISPENSE drops everything, no refund afterwards
        press(4'h3, 1'b1);
        press(4'h3, 1'b1);
        press(4'h4, 1'b1);
        check("rst_pre_credit", credit, 25);
        #3;
        reset = 1'b0;
        #1;
        check("rst_async_outputs",
              {credit, dispense, change, change_valid, coin_reject, deny, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (HOLD + 2) @(posedge clk);
        #1;
        check("rst_no_refund", {credit, change_valid, change, busy, dispense}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
